// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: PC, combinational imem read, prefetch FIFO, redirect.
// Optional IFU_MISALIGN_CHK_EN: flag and halt fetch on misaligned redirect.
module instr_fetch_unit #(
  parameter int          IMEM_W     = 14,
  parameter logic [31:0] RESET_PC   = 32'h0,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  output logic [IMEM_W-1:0] imem_paddr_o,
  input  logic [31:0]       imem_prdata_i,
  input  logic              redirect_i,
  input  logic [31:0]       redirect_pc_i,
  output logic [31:0]       instr_o,
  output logic [31:0]       pc_o,
  output logic              valid_o,
  input  logic              ready_i
`ifdef IFU_MISALIGN_CHK_EN
  ,
  output logic              misalign_o
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  entry_t          fifo_q [FIFO_DEPTH];
  logic [31:0]     fetch_pc;
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic            fetch_en;
  logic            push;
  logic            pop;
  logic [31:0]     redir_pc;
  logic            unused_lsb;

  assign redir_pc   = {redirect_pc_i[31:2], 2'b00};
  assign unused_lsb = ^redirect_pc_i[1:0];

`ifdef IFU_MISALIGN_CHK_EN
  logic halt_q;

  // Halt persists until an aligned redirect arrives.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      halt_q <= 1'b0;
    end else if (redirect_i) begin
      halt_q <= |redirect_pc_i[1:0];
    end
  end

  assign misalign_o = halt_q;
  assign fetch_en   = !halt_q;
`else
  assign fetch_en = 1'b1;
`endif

  assign valid_o = (count != '0);
  assign pop     = valid_o & ready_i & !redirect_i;
  assign push    = !redirect_i & fetch_en &
                   ((count < DEPTH_C) | pop);

  assign imem_paddr_o = {fetch_pc[IMEM_W-1:2], 2'b00};

  assign instr_o = valid_o ? fifo_q[rd_ptr].instr : '0;
  assign pc_o    = valid_o ? fifo_q[rd_ptr].pc : '0;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fetch_pc <= RESET_PC;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
    end else if (redirect_i) begin
      fetch_pc <= redir_pc;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
    end else begin
      if (push) begin
        fetch_pc <= fetch_pc + 32'd4;
        wr_ptr   <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Storage needs no reset; count gates visibility.
  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_q[wr_ptr] <= '{pc: fetch_pc, instr: imem_prdata_i};
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: directed scenarios plus random traffic
// checked against a stream-level model of the fetch sequence.
module tb_instr_fetch_unit;

  localparam int IMEM_W = 14;
  localparam int D      = 2;

  logic              clk_i = 1'b0;
  logic              rst_ni = 1'b0;
  logic [IMEM_W-1:0] imem_paddr_o;
  logic [31:0]       imem_prdata_i;
  logic              redirect_i = 1'b0;
  logic [31:0]       redirect_pc_i = '0;
  logic [31:0]       instr_o;
  logic [31:0]       pc_o;
  logic              valid_o;
  logic              ready_i = 1'b0;
`ifdef IFU_MISALIGN_CHK_EN
  logic              misalign_o;
`endif

  always #5 clk_i = ~clk_i;

  function automatic logic [31:0] mem_word(input logic [IMEM_W-1:0] a);
    return 32'(a >> 2);
  endfunction

  assign imem_prdata_i = mem_word(imem_paddr_o);

  instr_fetch_unit #(
    .IMEM_W(IMEM_W),
    .RESET_PC(32'h0),
    .FIFO_DEPTH(D)
  ) dut (
    .clk_i(clk_i),
    .rst_ni(rst_ni),
    .imem_paddr_o(imem_paddr_o),
    .imem_prdata_i(imem_prdata_i),
    .redirect_i(redirect_i),
    .redirect_pc_i(redirect_pc_i),
    .instr_o(instr_o),
    .pc_o(pc_o),
    .valid_o(valid_o),
    .ready_i(ready_i)
`ifdef IFU_MISALIGN_CHK_EN
    ,
    .misalign_o(misalign_o)
`endif
  );

  int checks = 0;
  int failures = 0;

  logic [31:0] redir_q [$];

  // Model: head_pc is the PC at the head of the stream, occ the buffered count.
  logic [31:0] m_head = '0;
  int          m_occ = 0;
  bit          m_halt = 1'b0;
  bit          mon_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk_i) begin
    logic [31:0]       t;
    logic [IMEM_W-1:0] ea;
    bit                pop;
    bit                push;
    if (mon_en) begin
      chk("valid", 32'(valid_o), 32'(m_occ > 0));
      if (m_occ > 0) begin
        chk("pc", pc_o, m_head);
        chk("instr", instr_o, mem_word(m_head[IMEM_W-1:0]));
      end else begin
        chk("pc_zero", pc_o, 32'h0);
        chk("instr_zero", instr_o, 32'h0);
      end
      ea = IMEM_W'(m_head + 32'(4 * m_occ));
      chk("paddr", 32'(imem_paddr_o), 32'(ea));
`ifdef IFU_MISALIGN_CHK_EN
      chk("misalign", 32'(misalign_o), 32'(m_halt));
`endif
      if (redirect_i) begin
        if (redir_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL redir_q: got empty expected entry at %0t", $time);
        end else begin
          t = redir_q.pop_front();
          m_head = {t[31:2], 2'b00};
          m_occ  = 0;
`ifdef IFU_MISALIGN_CHK_EN
          m_halt = |t[1:0];
`else
          m_halt = 1'b0;
`endif
        end
      end else begin
        pop  = (m_occ > 0) && ready_i;
        push = !m_halt && ((m_occ < D) || pop);
        if (pop) m_head = m_head + 32'd4;
        m_occ = m_occ + int'(push) - int'(pop);
      end
    end
  end

  task automatic cyc(input bit rdy, input bit rd, input logic [31:0] tgt);
    ready_i       = rdy;
    redirect_i    = rd;
    redirect_pc_i = tgt;
    if (rd) redir_q.push_back(tgt);
    @(posedge clk_i);
    #1;
  endtask

  function automatic logic [31:0] rand_tgt();
    logic [31:0] r;
    r = $urandom;
    case ($urandom % 5)
      0: return r;
      1: return r & 32'h0000_3FFF;
      2: return 32'hFFFF_FFF0 | (r & 32'hF);
      3: return 32'h0000_3FF0 | (r & 32'hC);
      default: return r & ~32'h3;
    endcase
  endfunction

  initial begin
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    chk("rst_valid", 32'(valid_o), 32'h0);
    chk("rst_pc", pc_o, 32'h0);
    chk("rst_instr", instr_o, 32'h0);
    chk("rst_paddr", 32'(imem_paddr_o), 32'h0);
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    m_head = 32'h0;
    m_occ  = 0;
    m_halt = 1'b0;
    mon_en = 1'b1;

    repeat (6) cyc(1, 0, '0);
    repeat (5) cyc(0, 0, '0);
    repeat (4) cyc(1, 0, '0);
    repeat (3) cyc(0, 0, '0);
    cyc(0, 1, 32'h100);
    repeat (4) cyc(1, 0, '0);
    cyc(1, 1, 32'h40);
    repeat (3) cyc(1, 0, '0);
    cyc(1, 1, 32'h3FFC);
    repeat (4) cyc(1, 0, '0);
    cyc(1, 1, 32'hFFFF_FFF8);
    repeat (4) cyc(1, 0, '0);
    cyc(1, 1, 32'h102);
    repeat (4) cyc(1, 0, '0);
    cyc(0, 1, 32'h200);
    repeat (4) cyc(1, 0, '0);
    cyc(1, 1, 32'h10);
    cyc(1, 1, 32'h20);
    cyc(1, 1, 32'h30);
    repeat (3) cyc(1, 0, '0);

    for (int i = 0; i < 3000; i++) begin
      if ($urandom % 10 == 0) cyc($urandom % 4 != 0, 1, rand_tgt());
      else cyc($urandom % 4 != 0, 0, '0);
    end
    cyc(1, 0, '0);
    mon_en = 1'b0;
    chk("redir_q_drain", 32'(redir_q.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
